// File: rtl/nic_pe_interface_if.sv
// Processor/router bundle for nic_pe_interface: register access port, both router
// channel handshakes, and the two channel FSM states for observation.
interface nic_pe_interface_if #(
  parameter int PACKET_SIZE = 64
);
  logic [1:0]             addr;
  logic [PACKET_SIZE-1:0] d_in;
  logic [PACKET_SIZE-1:0] d_out;
  logic                   nicEn;
  logic                   nicWrEn;
  logic                   net_so;
  logic                   net_ro;
  logic [PACKET_SIZE-1:0] net_do;
  logic                   net_polarity;
  logic                   net_si;
  logic                   net_ri;
  logic [PACKET_SIZE-1:0] net_di;
  logic                   ob_state_dbg;
  logic                   ib_state_dbg;

  // Router handshake: a packet moves on any clk edge where the sender's send and
  // the receiver's ready are both 1; send never waits on anything but ready and
  // (for net_so) the polarity match, and ready never depends on send.
  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri, ob_state_dbg, ib_state_dbg
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri, ob_state_dbg, ib_state_dbg
  );
endinterface

// File: rtl/nic_pe_interface.sv
// Network interface between a processor and a router PE port: one-entry output and
// input channel buffers. Define NIC_PKT_CNT_EN for 16-bit tx/rx packet counters.
module nic_pe_interface #(
  parameter int PACKET_SIZE = 64
) (
  input  logic             clk,
  input  logic             reset,
  nic_pe_interface_if.slave bus
);
  typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } chan_state_t;

  chan_state_t            ob_state;
  chan_state_t            ib_state;
  logic [PACKET_SIZE-1:0] ob;
  logic [PACKET_SIZE-1:0] ib;
  logic [PACKET_SIZE-1:0] d_out_q;
  logic [PACKET_SIZE-1:0] ib_status;
  logic [PACKET_SIZE-1:0] ob_status;
  logic                   send;
  logic                   capture;
  logic                   rd;
  logic                   wr;

`ifdef NIC_PKT_CNT_EN
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;
`endif

  assign rd      = bus.nicEn & ~bus.nicWrEn;
  assign wr      = bus.nicEn & bus.nicWrEn;
  // Only packets whose top bit matches the router's current polarity may leave.
  assign send    = (ob_state == FULL) & bus.net_ro & (ob[PACKET_SIZE-1] == bus.net_polarity);
  assign capture = bus.net_si & (ib_state == EMPTY);

  assign bus.net_so       = send;
  assign bus.net_do       = ob;
  assign bus.net_ri       = (ib_state == EMPTY);
  assign bus.d_out        = d_out_q;
  assign bus.ob_state_dbg = ob_state;
  assign bus.ib_state_dbg = ib_state;

  always_comb begin
    ib_status    = '0;
    ob_status    = '0;
    ib_status[0] = (ib_state == FULL);
    ob_status[0] = (ob_state == FULL);
`ifdef NIC_PKT_CNT_EN
    ib_status[47:32] = rx_cnt;
    ob_status[47:32] = tx_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ob_state <= EMPTY;
      ib_state <= EMPTY;
      ob       <= '0;
      ib       <= '0;
      d_out_q  <= '0;
`ifdef NIC_PKT_CNT_EN
      tx_cnt   <= '0;
      rx_cnt   <= '0;
`endif
    end else begin
      case (ob_state)
        EMPTY: if (wr && bus.addr == 2'b10) begin
          ob       <= bus.d_in;
          ob_state <= FULL;
        end
        FULL: if (send) ob_state <= EMPTY;
        default: ob_state <= EMPTY;
      endcase

      // Capture needs EMPTY and the processor clear needs FULL, so they never collide.
      case (ib_state)
        EMPTY: if (capture) begin
          ib       <= bus.net_di;
          ib_state <= FULL;
        end
        FULL: if (rd && bus.addr == 2'b00) ib_state <= EMPTY;
        default: ib_state <= EMPTY;
      endcase

      if (rd) begin
        case (bus.addr)
          2'b00:   d_out_q <= ib;
          2'b01:   d_out_q <= ib_status;
          2'b11:   d_out_q <= ob_status;
          default: d_out_q <= '0;
        endcase
      end

`ifdef NIC_PKT_CNT_EN
      if (send)    tx_cnt <= tx_cnt + 16'd1;
      if (capture) rx_cnt <= rx_cnt + 16'd1;
`endif
    end
  end
endmodule
